// File: rtl/alu_seq_pkg.sv
// Shared definitions for the alu_seq sequencer.
// Opcodes, FSM states, instruction field positions and field helpers.
package alu_seq_pkg;

    localparam int PC_W_DEF = 4;
    localparam int DATA_W   = 4;
    localparam int REG_AW   = 2;
    localparam int NREG     = 4;
    localparam int INSTR_W  = 8;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_LDI  = 2'b10;
    localparam logic [1:0] OP_HALT = 2'b11;

    localparam int OP_HI  = 7;
    localparam int OP_LO  = 6;
    localparam int RD_HI  = 5;
    localparam int RD_LO  = 4;
    localparam int RS_HI  = 3;
    localparam int RS_LO  = 2;
    localparam int RT_HI  = 1;
    localparam int RT_LO  = 0;
    localparam int IMM_HI = 3;
    localparam int IMM_LO = 0;

    typedef enum logic [1:0] {
        S_FETCH = 2'b00,
        S_EXEC  = 2'b01,
        S_WB    = 2'b10,
        S_HALT  = 2'b11
    } state_e;

    function automatic logic [1:0] op_of(input logic [INSTR_W-1:0] w);
        return w[OP_HI:OP_LO];
    endfunction

    function automatic logic [REG_AW-1:0] rd_of(input logic [INSTR_W-1:0] w);
        return w[RD_HI:RD_LO];
    endfunction

    function automatic logic [REG_AW-1:0] rs_of(input logic [INSTR_W-1:0] w);
        return w[RS_HI:RS_LO];
    endfunction

    function automatic logic [REG_AW-1:0] rt_of(input logic [INSTR_W-1:0] w);
        return w[RT_HI:RT_LO];
    endfunction

    function automatic logic [DATA_W-1:0] imm_of(input logic [INSTR_W-1:0] w);
        return w[IMM_HI:IMM_LO];
    endfunction

endpackage

// File: rtl/alu_seq_regfile_4x4.sv
// 4-entry x 4-bit register file.
// Two operand read ports, one debug read port, one synchronous write port.
module regfile_4x4
    import alu_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [REG_AW-1:0] ra_a_i,
    input  logic [REG_AW-1:0] ra_b_i,
    input  logic [REG_AW-1:0] dbg_sel_i,
    output logic [DATA_W-1:0] rd_a_o,
    output logic [DATA_W-1:0] rd_b_o,
    output logic [DATA_W-1:0] dbg_o
);

    logic [DATA_W-1:0] regs_q [NREG];

    // Register storage: cleared on reset, one write per cycle otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rd_a_o = regs_q[ra_a_i];
    assign rd_b_o = regs_q[ra_b_i];
    assign dbg_o  = regs_q[dbg_sel_i];

endmodule

// File: rtl/alu_seq.sv
// Instruction sequencer for the 4-bit alu: fetch, operand drive, writeback.
// Holds the FSM, PC, IR and the registered ALU operands.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int PC_W = PC_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    output logic [PC_W-1:0]    pc,
    output logic               instr_ready,
    input  logic               instr_valid,
    input  logic [INSTR_W-1:0] instr,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic               alu_c,
    input  logic [DATA_W-1:0]  alu_d,
    output logic               halted,
    input  logic [REG_AW-1:0]  dbg_sel,
    output logic [DATA_W-1:0]  dbg_data
);

    state_e               state_q;
    logic [PC_W-1:0]      pc_q;
    logic [PC_W-1:0]      pc_d;
    logic [INSTR_W-1:0]   ir_q;
    logic [DATA_W-1:0]    a_q;
    logic [DATA_W-1:0]    b_q;
    logic                 c_q;
    logic                 halted_q;
    logic [DATA_W-1:0]    rs_data;
    logic [DATA_W-1:0]    rt_data;
    logic                 wb_we;
    logic [DATA_W-1:0]    wb_data;

    // PC wraps naturally at 2^PC_W.
    assign pc_d = pc_q + 1'b1;

    assign wb_we   = (state_q == S_WB);
    assign wb_data = (op_of(ir_q) == OP_LDI) ? imm_of(ir_q) : alu_d;

    regfile_4x4 u_rf (
        .clk       (clk),
        .rst       (rst),
        .we_i      (wb_we),
        .waddr_i   (rd_of(ir_q)),
        .wdata_i   (wb_data),
        .ra_a_i    (rs_of(ir_q)),
        .ra_b_i    (rt_of(ir_q)),
        .dbg_sel_i (dbg_sel),
        .rd_a_o    (rs_data),
        .rd_b_o    (rt_data),
        .dbg_o     (dbg_data)
    );

    // Control FSM: fetch handshake, operand capture, PC advance, halt.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FETCH;
            pc_q     <= '0;
            ir_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_FETCH: begin
                    if (instr_valid) begin
                        ir_q <= instr;
                        unique case (op_of(instr))
                            OP_ADD, OP_SUB: state_q <= S_EXEC;
                            OP_LDI:         state_q <= S_WB;
                            OP_HALT: begin
                                state_q  <= S_HALT;
                                halted_q <= 1'b1;
                            end
                        endcase
                    end
                end
                S_EXEC: begin
                    a_q     <= rs_data;
                    b_q     <= rt_data;
                    c_q     <= ir_q[OP_LO];
                    state_q <= S_WB;
                end
                S_WB: begin
                    pc_q    <= pc_d;
                    state_q <= S_FETCH;
                end
                S_HALT: begin
                    state_q <= S_HALT;
                end
            endcase
        end
    end

    // Ready only in FETCH, and never while reset is being applied.
    assign instr_ready = (state_q == S_FETCH) && !rst;

    assign pc     = pc_q;
    assign alu_a  = a_q;
    assign alu_b  = b_q;
    assign alu_c  = c_q;
    assign halted = halted_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a behavioural 4-bit alu beside it.
// Instruction memory is indexed by pc; expectations are hand-computed.
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] pc;
    logic       instr_ready;
    logic       instr_valid;
    logic [7:0] instr;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic       alu_c;
    logic [3:0] alu_d;
    logic       halted;
    logic [1:0] dbg_sel;
    logic [3:0] dbg_data;

    logic [7:0] imem [16];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // The combinational alu: C=0 add, C=1 subtract, modulo 16.
    assign alu_d = alu_c ? (alu_a - alu_b) : (alu_a + alu_b);
    assign instr = imem[pc];

    alu_seq dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .instr_ready (instr_ready),
        .instr_valid (instr_valid),
        .instr       (instr),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_c       (alu_c),
        .alu_d       (alu_d),
        .halted      (halted),
        .dbg_sel     (dbg_sel),
        .dbg_data    (dbg_data)
    );

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Read a register through the debug port (costs 1 ns).
    task automatic chk_r(input string tag, input logic [1:0] sel,
                         input logic [3:0] exp);
        dbg_sel = sel;
        #1;
        chk(tag, {4'h0, dbg_data}, {4'h0, exp});
    endtask

    task automatic fill_halt();
        for (int i = 0; i < 16; i++) imem[i] = 8'hC0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        chk("ready_in_rst", {7'd0, instr_ready}, 8'h00);
        rst = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        instr_valid = 1'b1;
        dbg_sel     = 2'd0;
        fill_halt();

        // Load and add
        imem[0] = 8'h94;
        imem[1] = 8'hA1;
        imem[2] = 8'h36;
        do_reset();
        #1;
        chk("rst_pc", {4'h0, pc}, 8'h00);
        chk("rst_ready", {7'd0, instr_ready}, 8'h01);
        chk("rst_halted", {7'd0, halted}, 8'h00);
        chk("rst_abc", {3'd0, alu_c, alu_a}, 8'h00);
        chk("rst_b", {4'h0, alu_b}, 8'h00);
        chk_r("rst_r3", 2'd3, 4'h0);
        step(4);
        chk("la_pc2", {4'h0, pc}, 8'h02);
        chk_r("la_r1", 2'd1, 4'h4);
        chk_r("la_r2", 2'd2, 4'h1);
        step(1);
        chk("add_exec_ready", {7'd0, instr_ready}, 8'h00);
        step(1);
        chk("add_wb_a", {4'h0, alu_a}, 8'h04);
        chk("add_wb_b", {4'h0, alu_b}, 8'h01);
        chk("add_wb_c", {7'd0, alu_c}, 8'h00);
        chk_r("add_wb_r3_old", 2'd3, 4'h0);
        step(1);
        chk("add_pc3", {4'h0, pc}, 8'h03);
        chk("add_ready", {7'd0, instr_ready}, 8'h01);
        chk_r("add_r3", 2'd3, 4'h5);
        step(1);
        chk("halt_flag", {7'd0, halted}, 8'h01);
        chk("halt_ready", {7'd0, instr_ready}, 8'h00);
        chk("halt_pc", {4'h0, pc}, 8'h03);

        // Subtract and wraparound
        fill_halt();
        imem[0] = 8'h88;
        imem[1] = 8'h91;
        imem[2] = 8'h61;
        imem[3] = 8'h8E;
        imem[4] = 8'h95;
        imem[5] = 8'h31;
        do_reset();
        step(7);
        chk_r("sub_r2", 2'd2, 4'h7);
        chk("sub_c", {7'd0, alu_c}, 8'h01);
        step(8);
        chk_r("wrap_r3", 2'd3, 4'h3);
        chk_r("wrap_r2_keep", 2'd2, 4'h7);
        chk("wrap_a", {4'h0, alu_a}, 8'h0E);
        chk("wrap_b", {4'h0, alu_b}, 8'h05);
        chk("wrap_c", {7'd0, alu_c}, 8'h00);
        chk("wrap_halt", {3'd0, halted, pc}, 8'h16);

        // Fetch stall, then identical results to the first program
        fill_halt();
        imem[0] = 8'h94;
        imem[1] = 8'hA1;
        imem[2] = 8'h36;
        instr_valid = 1'b0;
        do_reset();
        step(5);
        chk("stall0_pc", {4'h0, pc}, 8'h00);
        chk("stall0_ready", {7'd0, instr_ready}, 8'h01);
        chk_r("stall0_r1", 2'd1, 4'h0);
        instr_valid = 1'b1;
        step(2);
        chk("stall1_pc", {4'h0, pc}, 8'h01);
        chk_r("stall1_r1", 2'd1, 4'h4);
        instr_valid = 1'b0;
        step(5);
        chk("stall2_pc", {4'h0, pc}, 8'h01);
        chk("stall2_ready", {7'd0, instr_ready}, 8'h01);
        chk("stall2_abc", {3'd0, alu_c, alu_a}, 8'h00);
        chk_r("stall2_r2", 2'd2, 4'h0);
        instr_valid = 1'b1;
        step(6);
        chk_r("stall_r3", 2'd3, 4'h5);
        chk("stall_end", {3'd0, halted, pc}, 8'h13);

        // Halt at pc=15 after 15 LDIs
        fill_halt();
        for (int i = 0; i < 15; i++) begin
            imem[i] = {2'b10, 2'(i % 4), 4'(i)};
        end
        do_reset();
        step(31);
        chk("h15_halted", {7'd0, halted}, 8'h01);
        chk("h15_ready", {7'd0, instr_ready}, 8'h00);
        chk("h15_pc", {4'h0, pc}, 8'h0F);
        chk_r("h15_r2", 2'd2, 4'hE);
        step(10);
        chk("h15_pc_hold", {4'h0, pc}, 8'h0F);
        chk_r("h15_r0_hold", 2'd0, 4'hC);
        chk_r("h15_r3_hold", 2'd3, 4'hB);

        // 16 LDIs, pc wraps 15 -> 0, HALT taken at pc=0
        imem[15] = 8'hBF;
        do_reset();
        step(32);
        chk("w16_pc", {4'h0, pc}, 8'h00);
        chk_r("w16_r3", 2'd3, 4'hF);
        imem[0] = 8'hC0;
        step(1);
        chk("w16_halt", {3'd0, halted, pc}, 8'h10);

        // Self-dependency
        fill_halt();
        imem[0] = 8'h93;
        imem[1] = 8'h15;
        imem[2] = 8'h15;
        do_reset();
        step(2);
        chk_r("self_r1_0", 2'd1, 4'h3);
        step(3);
        chk_r("self_r1_1", 2'd1, 4'h6);
        step(3);
        chk_r("self_r1_2", 2'd1, 4'hC);

        // Reset during EXEC of ADD R3,R1,R2
        fill_halt();
        imem[0] = 8'h94;
        imem[1] = 8'hA1;
        imem[2] = 8'h36;
        do_reset();
        step(5);
        chk("mid_in_exec", {7'd0, instr_ready}, 8'h00);
        rst = 1'b1;
        step(1);
        chk_r("mid_r3", 2'd3, 4'h0);
        chk_r("mid_r1", 2'd1, 4'h0);
        chk("mid_pc", {4'h0, pc}, 8'h00);
        chk("mid_ab", {alu_b, alu_a}, 8'h00);
        chk("mid_c_h", {6'd0, alu_c, halted}, 8'h00);
        rst = 1'b0;
        #1;
        chk("mid_req", {3'd0, instr_ready, pc}, 8'h10);
        step(2);
        chk("mid_rerun_pc", {4'h0, pc}, 8'h01);
        chk_r("mid_rerun_r1", 2'd1, 4'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
